seq_mult: RTL
=============

Name: seq_mult

Overview:
- Parametrised, iterative shift-add integer multiplier. Successor to the flat combinational adder-chain multipliers.
- Computes a full-width product over WIDTH/BITS_PER_CYCLE clock cycles, using one narrow adder stage. This trades latency for area.
- Sits in the PE datapath behind a valid/ready handshake on both input and output, so upstream and downstream can stall independently.

Parameters:
- WIDTH, 32, operand width in bits; product is 2*WIDTH bits.
- BITS_PER_CYCLE, 1, multiplier bits consumed per iteration (1, 2 or 4); WIDTH must be divisible by it.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- out_valid  output  1  product valid.
- out_ready  input  1  downstream accepts product.
- product  output  2*WIDTH  a*b.
- busy  output  1  iteration in progress.

Behaviour:
- Reset (rst_n low, async): state IDLE, counter 0, accumulator 0, product 0, out_valid 0, busy 0. in_ready is 1 once in IDLE.
- Reset mid-operation aborts the operation: no out_valid and no partial product is visible afterwards.
- FSM states are IDLE, BUSY, DONE.
- IDLE: in_ready=1. On the edge where in_valid&&in_ready:
  - latch a into the multiplicand register and b into the multiplier shift register;
  - clear the accumulator;
  - load the counter with STEPS = WIDTH/BITS_PER_CYCLE;
  - go to BUSY.
- BUSY: in_ready=0, busy=1. Each cycle:
  - add (multiplicand * low BITS_PER_CYCLE bits of the multiplier) into the accumulator upper half, WIDTH+BITS_PER_CYCLE bits wide;
  - shift the accumulator right by BITS_PER_CYCLE;
  - shift the multiplier right by BITS_PER_CYCLE;
  - decrement the counter.
  - When the counter reaches 0, register product and go to DONE.
- DONE: out_valid=1, product held stable. in_ready=0. On out_valid&&out_ready, go to IDLE and drop out_valid next cycle.
  - out_ready low holds DONE indefinitely, with product and out_valid unchanged.
- Latency: the accept edge is cycle 0. out_valid rises exactly STEPS+1 cycles later. WIDTH=32, BPC=1 gives 33 cycles; BPC=4 gives 9 cycles.
- Throughput: at most one operation per STEPS+2 cycles. There is no overlap; in_ready is low in BUSY and DONE.
- Arithmetic:
  - Unsigned by default. The product is exact, with no truncation or overflow for any inputs.
  - Carry out of each partial add is kept in the accumulator MSB.
- Inputs a and b are sampled only on the accept edge. Later changes, and in_valid while not ready, are ignored.
- product keeps the last result after returning to IDLE until the next result is registered.

Optional Feature:
- Macro: SEQ_MULT_SIGNED_EN.
- When defined:
  - adds input port signed_mode (1 bit), sampled on the accept edge.
  - If signed_mode=1, a and b are two's complement. The block multiplies magnitudes and negates the product if the sign bits differ.
  - The most negative operand, -2^(WIDTH-1), is handled exactly. Latency is unchanged.
  - signed_mode=0 behaves as unsigned.
- When undefined: no signed_mode port; unsigned only.

Test Plan:
- WIDTH=32, BPC=1, out_ready=1: accept a=0xFFFFFFFF, b=0xFFFFFFFF -> out_valid after 33 cycles, product=0xFFFFFFFE00000001, one cycle pulse.
- a=0, b=0x12345678 and a=1, b=0xDEADBEEF -> product 0 and 0x00000000DEADBEEF.
- Hold out_ready=0 for 10 cycles after out_valid with a=7, b=6:
  - product=42 stable;
  - in_ready=0 throughout, and in_valid pulses are ignored;
  - out_ready=1 -> IDLE, in_ready=1 next cycle.
- Assert rst_n=0 at cycle 12 of a BUSY operation -> out_valid, busy, product all 0 immediately. After release, in_ready=1 and a new op 3*5 gives 15.
- BPC=4, a=0x80000000, b=0x2 -> out_valid after 9 cycles, product=0x0000000100000000.
- SEQ_MULT_SIGNED_EN, signed_mode=1:
  - -3*5 -> 0xFFFFFFFFFFFFFFF1;
  - 0x80000000*0x80000000 -> 0x4000000000000000;
  - signed_mode=0 with the same first inputs -> 0x00000004FFFFFFF1.

Source files
------------

// File: rtl/seq_mult.sv
// seq_mult: iterative shift-add multiplier retiring BITS_PER_CYCLE multiplier bits per clock.
// Optional macro SEQ_MULT_SIGNED_EN adds the signed_mode port for two's-complement operands.
module seq_mult #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef SEQ_MULT_SIGNED_EN
  input  logic                 signed_mode,
`endif
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic [1:0]           dbg_state
);
  localparam int BPC   = BITS_PER_CYCLE;
  localparam int STEPS = WIDTH / BPC;
  localparam int CW    = $clog2(STEPS + 1);
  localparam int AW    = WIDTH + BPC;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0]       mcand;
  logic [WIDTH-1:0]       mplier;
  logic [2*WIDTH-1:0]     acc;
  logic [CW-1:0]          cnt;
  logic                   neg;

  logic                   accept;
  logic [WIDTH-1:0]       a_mag;
  logic [WIDTH-1:0]       b_mag;
  logic                   neg_in;
  logic [AW-1:0]          pp;
  logic [AW-1:0]          sum;
  logic [2*WIDTH+BPC-1:0] wide;
  logic [2*WIDTH-1:0]     acc_step;
  logic [2*WIDTH-1:0]     result;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // in_valid/a/b are only looked at in IDLE; product/out_valid stay frozen in DONE until out_ready.
  assign accept    = in_valid && in_ready;
  assign dbg_state = state;

`ifdef SEQ_MULT_SIGNED_EN
  // Magnitudes fit in WIDTH unsigned bits, including -2^(WIDTH-1).
  always_comb begin
    a_mag  = a;
    b_mag  = b;
    neg_in = 1'b0;
    if (signed_mode) begin
      if (a[WIDTH-1]) a_mag = -a;
      if (b[WIDTH-1]) b_mag = -b;
      neg_in = a[WIDTH-1] ^ b[WIDTH-1];
    end
  end
`else
  assign a_mag  = a;
  assign b_mag  = b;
  assign neg_in = 1'b0;
`endif

  // One narrow partial product per cycle; the carry lands in the top bit of sum.
  always_comb begin
    pp       = AW'(mcand) * AW'(mplier[BPC-1:0]);
    sum      = AW'(acc[2*WIDTH-1:WIDTH]) + pp;
    wide     = {sum, acc[WIDTH-1:0]};
    acc_step = wide[2*WIDTH+BPC-1:BPC];
    result   = neg ? -acc : acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The cycle after the last iteration (counter at zero) publishes the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      product <= '0;
    end else if (accept) begin
      mcand  <= a_mag;
      mplier <= b_mag;
      acc    <= '0;
      cnt    <= CW'(STEPS);
      neg    <= neg_in;
    end else if (busy) begin
      if (cnt != '0) begin
        acc    <= acc_step;
        mplier <= mplier >> BPC;
        cnt    <= cnt - CW'(1);
      end else begin
        product <= result;
      end
    end
  end

endmodule
